// File: rtl/wdt_timer_ctrl.sv
// wdt_timer_ctrl: watchdog countdown sequencer for the WDT block.
// Owns the down-counter and the timeout FSM (IDLE -> RUN -> ARMED -> RESET).
// The first expiry raises wdt_int. A second unserviced expiry either pulses
// wdt_reset for RST_PULSE cycles, or strobes test_reset when test mode is on.
// Ports:
//   pclk, presetn     : APB clock, async active-low reset
//   load_wr, load_val : load register write strobe and current load value
//   int_en, resen     : watchdog enable, reset enable
//   stall_en, dbg_halt: freeze counting while the CPU is halted in debug
//   test              : replace the system reset with the test_reset strobe
//   icr_clr           : interrupt clear (service) strobe
//   cnt_value         : current count (registered)
//   value_eq0         : expiry strobe (combinational)
//   wdt_int           : interrupt level (registered)
//   wdt_reset         : system reset request pulse (registered)
//   test_reset        : suppressed-reset strobe (registered)
module wdt_timer_ctrl #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned RST_PULSE = 4
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic             load_wr,
   input  logic [CNT_W-1:0] load_val,
   input  logic             int_en,
   input  logic             resen,
   input  logic             stall_en,
   input  logic             dbg_halt,
   input  logic             test,
   input  logic             icr_clr,
   output logic [CNT_W-1:0] cnt_value,
   output logic             value_eq0,
   output logic             wdt_int,
   output logic             wdt_reset,
   output logic             test_reset
);

   localparam int unsigned PULSE_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      ARMED = 2'd2,
      RESET = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PULSE_W-1:0] pulse_q, pulse_d;
   logic               int_q, int_d;
   logic               rst_q, rst_d;
   logic               trst_q, trst_d;
   logic               stall_c;
   logic               cnt_en_c;
   logic               eq0_c;

   // Counting qualifiers and the expiry strobe; a load or service in the
   // same cycle as zero suppresses the expiry.
   always_comb begin
      stall_c  = stall_en & dbg_halt;
      cnt_en_c = ((state_q == RUN) || (state_q == ARMED)) & ~stall_c;
      eq0_c    = cnt_en_c & (cnt_q == '0) & ~load_wr & ~icr_clr;
   end

   // State and output registers.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= IDLE;
         cnt_q   <= '1;
         pulse_q <= '0;
         int_q   <= 1'b0;
         rst_q   <= 1'b0;
         trst_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         int_q   <= int_d;
         rst_q   <= rst_d;
         trst_q  <= trst_d;
      end
   end

   // Next-state, counter and output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = pulse_q;
      int_d   = int_q;
      rst_d   = rst_q;
      trst_d  = 1'b0;

      // Counter: RESET holds until the pulse ends, then reloads.
      if (state_q == RESET) begin
         if (pulse_q == '0) begin
            cnt_d = load_val;
         end
      end else if (load_wr || icr_clr) begin
         cnt_d = load_val;
      end else if (eq0_c) begin
         cnt_d = load_val;
      end else if (cnt_en_c) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (int_en && !stall_c) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!stall_c) begin
               if (!int_en) begin
                  state_d = IDLE;
               end else if (eq0_c) begin
                  state_d = ARMED;
                  int_d   = 1'b1;
               end
            end
         end
         ARMED: begin
            // Service beats a coincident expiry; eq0_c is already low then.
            if (!int_en && !stall_c) begin
               state_d = IDLE;
               int_d   = 1'b0;
            end else if (icr_clr) begin
               state_d = RUN;
               int_d   = 1'b0;
            end else if (eq0_c && resen) begin
               if (test) begin
                  trst_d = 1'b1;
               end else begin
                  state_d = RESET;
                  rst_d   = 1'b1;
                  pulse_d = PULSE_W'(RST_PULSE - 1);
               end
            end
         end
         RESET: begin
            // pulse_q counts RST_PULSE-1 down to 0: RST_PULSE cycles high.
            if (pulse_q == '0) begin
               state_d = RUN;
               rst_d   = 1'b0;
               int_d   = 1'b0;
            end else begin
               pulse_d = pulse_q - PULSE_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cnt_value  = cnt_q;
   assign value_eq0  = eq0_c;
   assign wdt_int    = int_q;
   assign wdt_reset  = rst_q;
   assign test_reset = trst_q;

endmodule

// File: tb/tb_wdt_timer_ctrl.sv
// Testbench for wdt_timer_ctrl: per-cycle expected outputs are queued by the
// stimulus and compared by a negedge monitor.
module tb_wdt_timer_ctrl;

   localparam int unsigned CNT_W = 32;
   localparam logic [CNT_W-1:0] ONES = '1;

   logic             pclk;
   logic             presetn;
   logic             load_wr;
   logic [CNT_W-1:0] load_val;
   logic             int_en;
   logic             resen;
   logic             stall_en;
   logic             dbg_halt;
   logic             test;
   logic             icr_clr;
   logic [CNT_W-1:0] cnt_value;
   logic             value_eq0;
   logic             wdt_int;
   logic             wdt_reset;
   logic             test_reset;

   typedef struct {
      string            tag;
      logic [CNT_W-1:0] cnt;
      logic             eq0;
      logic             irq;
      logic             rst;
      logic             trst;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   wdt_timer_ctrl #(.CNT_W(32), .RST_PULSE(4)) dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .load_wr    (load_wr),
      .load_val   (load_val),
      .int_en     (int_en),
      .resen      (resen),
      .stall_en   (stall_en),
      .dbg_halt   (dbg_halt),
      .test       (test),
      .icr_clr    (icr_clr),
      .cnt_value  (cnt_value),
      .value_eq0  (value_eq0),
      .wdt_int    (wdt_int),
      .wdt_reset  (wdt_reset),
      .test_reset (test_reset)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, expv);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic nxt();
      @(posedge pclk);
      #1;
   endtask

   task automatic expect_cyc(input string tag, input logic [CNT_W-1:0] cnt,
                             input logic eq0, input logic irq, input logic rst, input logic trst);
      exp_t e;
      e.tag = tag; e.cnt = cnt; e.eq0 = eq0; e.irq = irq; e.rst = rst; e.trst = trst;
      exp_q.push_back(e);
   endtask

   // Monitor: one queued expectation per cycle, compared mid-cycle.
   always @(negedge pclk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.tag, ".cnt"},  cnt_value, e.cnt);
         chk({e.tag, ".eq0"},  CNT_W'(value_eq0),  CNT_W'(e.eq0));
         chk({e.tag, ".int"},  CNT_W'(wdt_int),    CNT_W'(e.irq));
         chk({e.tag, ".rst"},  CNT_W'(wdt_reset),  CNT_W'(e.rst));
         chk({e.tag, ".trst"}, CNT_W'(test_reset), CNT_W'(e.trst));
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      presetn = 1'b0; load_wr = 1'b0; load_val = '0; int_en = 1'b0; resen = 1'b0;
      stall_en = 1'b0; dbg_halt = 1'b0; test = 1'b0; icr_clr = 1'b0;

      // Reset state
      nxt(); expect_cyc("reset", ONES, 0, 0, 0, 0);
      nxt(); presetn = 1'b1; expect_cyc("idle", ONES, 0, 0, 0, 0);

      // Basic expiry: load 5, enable
      nxt(); load_wr = 1'b1; load_val = 32'd5; expect_cyc("ld5", ONES, 0, 0, 0, 0);
      nxt(); load_wr = 1'b0; int_en = 1'b1; expect_cyc("idle5", 32'd5, 0, 0, 0, 0);
      nxt(); expect_cyc("run5", 32'd5, 0, 0, 0, 0);
      for (int v = 4; v >= 1; v--) begin nxt(); expect_cyc("run", CNT_W'(v), 0, 0, 0, 0); end
      nxt(); expect_cyc("exp1", 32'd0, 1, 0, 0, 0);
      nxt(); expect_cyc("armed", 32'd5, 0, 1, 0, 0);

      // Second expiry with resen=0: stay armed
      for (int v = 4; v >= 1; v--) begin nxt(); expect_cyc("armed_cnt", CNT_W'(v), 0, 1, 0, 0); end
      nxt(); expect_cyc("exp2_nores", 32'd0, 1, 1, 0, 0);
      nxt(); expect_cyc("armed_again", 32'd5, 0, 1, 0, 0);

      // Service race: icr_clr coincides with zero
      nxt(); resen = 1'b1; expect_cyc("race_cnt", 32'd4, 0, 1, 0, 0);
      for (int v = 3; v >= 1; v--) begin nxt(); expect_cyc("race_cnt", CNT_W'(v), 0, 1, 0, 0); end
      nxt(); icr_clr = 1'b1; expect_cyc("race_zero", 32'd0, 0, 1, 0, 0);
      nxt(); icr_clr = 1'b0; expect_cyc("serviced", 32'd5, 0, 0, 0, 0);
      for (int v = 4; v >= 1; v--) begin nxt(); expect_cyc("run2", CNT_W'(v), 0, 0, 0, 0); end
      nxt(); expect_cyc("exp_run2", 32'd0, 1, 0, 0, 0);
      nxt(); expect_cyc("armed2", 32'd5, 0, 1, 0, 0);

      // Load in ARMED keeps wdt_int, then reset on second expiry
      nxt(); load_wr = 1'b1; load_val = 32'd3; expect_cyc("ld3_armed", 32'd4, 0, 1, 0, 0);
      nxt(); load_wr = 1'b0; expect_cyc("armed3", 32'd3, 0, 1, 0, 0);
      nxt(); expect_cyc("armed3", 32'd2, 0, 1, 0, 0);
      nxt(); expect_cyc("armed3", 32'd1, 0, 1, 0, 0);
      nxt(); expect_cyc("exp_rst", 32'd0, 1, 1, 0, 0);
      nxt(); icr_clr = 1'b1; expect_cyc("pulse1", 32'd3, 0, 1, 1, 0);
      nxt(); expect_cyc("pulse2", 32'd3, 0, 1, 1, 0);
      nxt(); expect_cyc("pulse3", 32'd3, 0, 1, 1, 0);
      nxt(); expect_cyc("pulse4", 32'd3, 0, 1, 1, 0);
      nxt(); icr_clr = 1'b0; expect_cyc("post_rst", 32'd3, 0, 0, 0, 0);
      nxt(); expect_cyc("post_run", 32'd2, 0, 0, 0, 0);
      nxt(); expect_cyc("post_run", 32'd1, 0, 0, 0, 0);
      nxt(); expect_cyc("post_exp", 32'd0, 1, 0, 0, 0);
      nxt(); expect_cyc("armed4", 32'd3, 0, 1, 0, 0);

      // Test mode: second expiry strobes test_reset only
      nxt(); test = 1'b1; expect_cyc("tm_cnt", 32'd2, 0, 1, 0, 0);
      nxt(); expect_cyc("tm_cnt", 32'd1, 0, 1, 0, 0);
      nxt(); expect_cyc("tm_exp", 32'd0, 1, 1, 0, 0);
      nxt(); expect_cyc("tm_trst", 32'd3, 0, 1, 0, 1);
      nxt(); expect_cyc("tm_after", 32'd2, 0, 1, 0, 0);

      // Async reset during the second cycle of the pulse
      nxt(); test = 1'b0; expect_cyc("ar_cnt", 32'd1, 0, 1, 0, 0);
      nxt(); expect_cyc("ar_exp", 32'd0, 1, 1, 0, 0);
      nxt(); expect_cyc("ar_pulse1", 32'd3, 0, 1, 1, 0);
      nxt();
      chk("ar_pulse2_rst", CNT_W'(wdt_reset), CNT_W'(1'b1));
      presetn = 1'b0; int_en = 1'b0; resen = 1'b0; load_val = 32'd0;
      #1;
      chk("ar_rst_now", CNT_W'(wdt_reset), CNT_W'(1'b0));
      chk("ar_cnt_now", cnt_value, ONES);
      chk("ar_int_now", CNT_W'(wdt_int), CNT_W'(1'b0));
      nxt(); expect_cyc("ar_hold", ONES, 0, 0, 0, 0);

      // Release: IDLE shown by one non-counting cycle after int_en=1
      nxt(); presetn = 1'b1; int_en = 1'b1; expect_cyc("ar_idle", ONES, 0, 0, 0, 0);
      nxt(); load_wr = 1'b1; load_val = 32'd7; expect_cyc("ar_run", ONES, 0, 0, 0, 0);

      // Debug stall at 7
      nxt(); load_wr = 1'b0; stall_en = 1'b1; dbg_halt = 1'b1;
      expect_cyc("stall", 32'd7, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin nxt(); expect_cyc("stall", 32'd7, 0, 0, 0, 0); end
      nxt(); dbg_halt = 1'b0; expect_cyc("unstall", 32'd7, 0, 0, 0, 0);
      nxt(); stall_en = 1'b0; dbg_halt = 1'b1; expect_cyc("dec6", 32'd6, 0, 0, 0, 0);
      nxt(); expect_cyc("halt_nostall", 32'd5, 0, 0, 0, 0);
      nxt(); expect_cyc("halt_nostall", 32'd4, 0, 0, 0, 0);

      // load_val = 0: expiry every counting cycle; int_en=0 disarms
      nxt(); dbg_halt = 1'b0; load_wr = 1'b1; load_val = 32'd0; expect_cyc("ld0", 32'd3, 0, 0, 0, 0);
      nxt(); load_wr = 1'b0; expect_cyc("z_exp1", 32'd0, 1, 0, 0, 0);
      nxt(); expect_cyc("z_exp2", 32'd0, 1, 1, 0, 0);
      nxt(); int_en = 1'b0; expect_cyc("z_dis", 32'd0, 1, 1, 0, 0);
      nxt(); expect_cyc("z_idle", 32'd0, 0, 0, 0, 0);
      nxt(); expect_cyc("z_idle2", 32'd0, 0, 0, 0, 0);

      nxt(); nxt();
      chk("queue_drained", CNT_W'(exp_q.size()), CNT_W'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
